// File: rtl/vfreq_pkg.sv
// Shared types and constants for the vfreq_meter period meter.
package vfreq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } vfreq_meter_state_t;

  localparam int VFREQ_CNT_W_DEF = 16;
  localparam int VFREQ_AVG_LOG2  = 2;

endpackage

// File: rtl/vfreq_edge_sync.sv
// Multi-flop synchronizer for an asynchronous input followed by a
// registered rising-edge detector producing a single-cycle rise pulse.
module vfreq_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the input through the synchronizer, keep the previous synchronized
  // sample and flag a 0->1 transition one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/vfreq_meter.sv
// Single-shot period meter: counts clk cycles between consecutive rising
// edges of an asynchronous input, with a saturating overflow flag.
// Optional build macro VFREQ_AVG_EN averages over four consecutive periods.
module vfreq_meter
  import vfreq_pkg::*;
#(
  parameter int CNT_W       = VFREQ_CNT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             overflow
);

`ifdef VFREQ_AVG_EN
  localparam int ACC_W = CNT_W + VFREQ_AVG_LOG2;
`else
  localparam int ACC_W = CNT_W;
`endif

  localparam logic [ACC_W-1:0] ACC_MAX    = '1;
  localparam logic [ACC_W-1:0] ACC_ONE    = ACC_W'(1);
  localparam logic [CNT_W-1:0] PERIOD_MAX = '1;

  vfreq_meter_state_t state, next_state;
  logic [ACC_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   result;
  logic               rise;
  logic               final_edge;
  logic               load_result;
  logic               saturate;

  vfreq_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk   (clk),
    .reset (reset),
    .sig_in(sig_in),
    .rise  (rise)
  );

`ifdef VFREQ_AVG_EN
  logic [1:0] ivl_q, ivl_d;

  assign final_edge = rise && (ivl_q == 2'd3);
  assign result     = cnt_q[ACC_W-1:VFREQ_AVG_LOG2];

  // Interval counter tracking how many full periods have been accumulated.
  always_ff @(posedge clk) begin
    if (reset) ivl_q <= 2'd0;
    else       ivl_q <= ivl_d;
  end
`else
  assign final_edge = rise;
  assign result     = cnt_q;
`endif

  // busy covers the whole measurement including the strobe cycle, which
  // also blocks a start arriving together with period_valid.
  assign busy = (state != IDLE) || period_valid;

  // State and period counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt_q <= '0;
    end else begin
      state <= next_state;
      cnt_q <= cnt_d;
    end
  end

  // Next-state logic: arm on start, begin counting at the first edge, finish
  // at the closing edge or when the counter would otherwise wrap.
  always_comb begin
    next_state  = state;
    cnt_d       = cnt_q;
    load_result = 1'b0;
    saturate    = 1'b0;
`ifdef VFREQ_AVG_EN
    ivl_d       = ivl_q;
`endif
    case (state)
      IDLE: begin
        if (start && !busy) next_state = ARM;
      end
      ARM: begin
        if (rise) begin
          cnt_d      = ACC_ONE;
          next_state = MEASURE;
`ifdef VFREQ_AVG_EN
          ivl_d      = 2'd0;
`endif
        end
      end
      MEASURE: begin
        if (final_edge) begin
          load_result = 1'b1;
          next_state  = IDLE;
        end else if (cnt_q == ACC_MAX) begin
          saturate   = 1'b1;
          next_state = IDLE;
        end else begin
          cnt_d = cnt_q + ACC_ONE;
`ifdef VFREQ_AVG_EN
          if (rise) ivl_d = ivl_q + 2'd1;
`endif
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Result registers: period/overflow update together with the strobe and
  // hold until the next result.
  always_ff @(posedge clk) begin
    if (reset) begin
      period       <= '0;
      overflow     <= 1'b0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= load_result || saturate;
      if (load_result) begin
        period   <= result;
        overflow <= 1'b0;
      end else if (saturate) begin
        period   <= PERIOD_MAX;
        overflow <= 1'b1;
      end
    end
  end

endmodule
